// File: rtl/uart_word_loader_if.sv
// Byte-stream in / memory-program-port out bundle for the UART word loader.
// master = the loader itself, slave = whoever feeds bytes and watches the writes.
interface uart_word_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              upg_wen_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;
    logic              upg_done_o;
    logic              load_err_o;
    logic [15:0]       words_loaded_o;

    modport master (
        input  rx_data, rx_valid,
        output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, load_err_o, words_loaded_o
    );

    modport slave (
        output rx_data, rx_valid,
        input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, load_err_o, words_loaded_o
    );
endinterface

// File: rtl/uart_word_loader.sv
// Assembles framed UART bytes (SYNC, LEN_LO, LEN_HI, 4*N data, CHK) into
// little-endian words and writes them to sequential data-memory addresses.
module uart_word_loader #(
    parameter int         ADDR_W    = 14,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_word_loader_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CHK    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam int          TW    = $clog2(TIMEOUT + 1);
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    logic [2:0]        state;
    logic [15:0]       len;
    logic [1:0]        lane;
    logic [23:0]       partial;
    logic [7:0]        sum;
    logic [16:0]       widx;
    logic [TW-1:0]     tcnt;
    logic              wen;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
    logic              done;
    logic              err;
    logic [15:0]       wl;

    logic       busy;
    logic       tmo;
    logic       issue;
    logic       last;
    logic [7:0] d;

    assign d     = bus.rx_data;
    assign busy  = (state != S_IDLE) && (state != S_DONE);
    assign tmo   = busy && !bus.rx_valid && (tcnt == TW'(TIMEOUT - 1));
    // Words beyond the memory depth are consumed but never written.
    assign issue = ({15'd0, widx} < DEPTH);
    assign last  = ((widx + 17'd1) == {1'b0, len});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len     <= '0;
            lane    <= '0;
            partial <= '0;
            sum     <= '0;
            widx    <= '0;
            tcnt    <= '0;
            wen     <= 1'b0;
            adr     <= '0;
            dat     <= '0;
            done    <= 1'b1;
            err     <= 1'b0;
            wl      <= '0;
        end else begin
            wen <= 1'b0;
            if (busy) tcnt <= bus.rx_valid ? '0 : tcnt + TW'(1);

            if (tmo) begin
                state <= S_IDLE;
                done  <= 1'b1;
                err   <= 1'b1;
                lane  <= '0;
                tcnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.rx_valid && d == SYNC_BYTE) begin
                            state <= S_LEN_LO;
                            err   <= 1'b0;
                            wl    <= '0;
                            sum   <= '0;
                            widx  <= '0;
                            lane  <= '0;
                            done  <= 1'b0;
                            tcnt  <= '0;
                        end
                    end
                    S_LEN_LO: begin
                        if (bus.rx_valid) begin
                            len[7:0] <= d;
                            sum      <= sum + d;
                            state    <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (bus.rx_valid) begin
                            len[15:8] <= d;
                            sum       <= sum + d;
                            state     <= ({d, len[7:0]} == 16'd0) ? S_CHK : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (bus.rx_valid) begin
                            sum <= sum + d;
                            if (lane == 2'd3) begin
                                lane  <= '0;
                                state <= S_WRITE;
                                if (issue) begin
                                    wen <= 1'b1;
                                    adr <= widx[ADDR_W-1:0];
                                    dat <= {d, partial};
                                end
                            end else begin
                                partial[lane*8 +: 8] <= d;
                                lane                 <= lane + 2'd1;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (wen) wl <= wl + 16'd1;
                        widx <= widx + 17'd1;
                        if (last) begin
                            // A byte arriving here is the checksum itself.
                            if (bus.rx_valid) begin
                                err   <= (d != sum);
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                state <= S_CHK;
                            end
                        end else begin
                            state <= S_DATA;
                            if (bus.rx_valid) begin
                                partial[7:0] <= d;
                                lane         <= 2'd1;
                                sum          <= sum + d;
                            end
                        end
                    end
                    S_CHK: begin
                        if (bus.rx_valid) begin
                            err   <= (d != sum);
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        tcnt  <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.upg_wen_o      = wen;
    assign bus.upg_adr_o      = adr;
    assign bus.upg_dat_o      = dat;
    assign bus.upg_done_o     = done;
    assign bus.load_err_o     = err;
    assign bus.words_loaded_o = wl;
endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader: a full-depth instance and a 4-word
// instance share one byte stream; each scenario checks its own results.
module tb_uart_word_loader;
    localparam int TMO = 64;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    int         checks;
    int         failures;

    uart_word_loader_if #(.ADDR_W(14)) ifa ();
    uart_word_loader_if #(.ADDR_W(2))  ifb ();

    assign ifa.rx_data  = rx_data;
    assign ifa.rx_valid = rx_valid;
    assign ifb.rx_data  = rx_data;
    assign ifb.rx_valid = rx_valid;

    uart_word_loader #(.ADDR_W(14), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.master));
    uart_word_loader #(.ADDR_W(2), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic [1:0]  logb_adr[$];
    logic [31:0] logb_dat[$];

    always @(posedge clk) begin
        if (ifa.upg_wen_o) begin
            log_adr.push_back(ifa.upg_adr_o);
            log_dat.push_back(ifa.upg_dat_o);
        end
        if (ifb.upg_wen_o) begin
            logb_adr.push_back(ifb.upg_adr_o);
            logb_dat.push_back(ifb.upg_dat_o);
        end
    end

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic gap();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // 8-bit wrapping sum over frame body (length + data).
    function automatic logic [7:0] csum(input logic [7:0] q[$]);
        logic [7:0] s = 8'h00;
        foreach (q[i]) s = s + q[i];
        return s;
    endfunction

    task automatic send(input logic [7:0] q[$], input bit b2b);
        foreach (q[i]) begin
            put(q[i]);
            if (!b2b) gap();
        end
        if (b2b) gap();
    endtask

    task automatic clear_logs();
        log_adr.delete(); log_dat.delete(); logb_adr.delete(); logb_dat.delete();
    endtask

    task automatic test_reset();
        checks++; if (ifa.upg_wen_o !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", ifa.upg_wen_o); end
        checks++; if (ifa.upg_adr_o !== 14'd0) begin failures++; $display("FAIL reset_adr got=%h exp=0", ifa.upg_adr_o); end
        checks++; if (ifa.upg_dat_o !== 32'd0) begin failures++; $display("FAIL reset_dat got=%h exp=0", ifa.upg_dat_o); end
        checks++; if (ifa.upg_done_o !== 1'b1) begin failures++; $display("FAIL reset_done got=%b exp=1", ifa.upg_done_o); end
        checks++; if (ifa.load_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", ifa.load_err_o); end
        checks++; if (ifa.words_loaded_o !== 16'd0) begin failures++; $display("FAIL reset_wl got=%0d exp=0", ifa.words_loaded_o); end
    endtask

    // Two words with spaced bytes; wen must appear exactly one cycle after each 4th byte.
    task automatic test_basic(input logic [7:0] chk_xor, input logic exp_err, input string tag);
        logic [7:0] body[$];
        logic [7:0] dbytes[8];
        dbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        body = {8'h02, 8'h00};
        foreach (dbytes[i]) body.push_back(dbytes[i]);
        clear_logs();
        put(8'hA5); gap();
        put(8'h02); gap();
        checks++; if (ifa.upg_done_o !== 1'b0) begin failures++; $display("FAIL %s_busy done=%b exp=0", tag, ifa.upg_done_o); end
        put(8'h00); gap();
        for (int i = 0; i < 8; i++) begin
            put(dbytes[i]);
            gap();
            checks++;
            if (ifa.upg_wen_o !== (i % 4 == 3)) begin
                failures++; $display("FAIL %s_wen_byte%0d got=%b exp=%b", tag, i, ifa.upg_wen_o, (i % 4 == 3));
            end
        end
        put(csum(body) ^ chk_xor); gap();
        @(negedge clk);
        checks++; if (log_adr.size() != 2) begin failures++; $display("FAIL %s_nwrites got=%0d exp=2", tag, log_adr.size()); end
        else begin
            checks++; if (log_adr[0] !== 14'd0 || log_dat[0] !== 32'h44332211) begin failures++; $display("FAIL %s_w0 adr=%h dat=%h exp 0/44332211", tag, log_adr[0], log_dat[0]); end
            checks++; if (log_adr[1] !== 14'd1 || log_dat[1] !== 32'h88776655) begin failures++; $display("FAIL %s_w1 adr=%h dat=%h exp 1/88776655", tag, log_adr[1], log_dat[1]); end
        end
        checks++; if (ifa.upg_done_o !== 1'b1) begin failures++; $display("FAIL %s_done got=%b exp=1", tag, ifa.upg_done_o); end
        checks++; if (ifa.load_err_o !== exp_err) begin failures++; $display("FAIL %s_err got=%b exp=%b", tag, ifa.load_err_o, exp_err); end
        checks++; if (ifa.words_loaded_o !== 16'd2) begin failures++; $display("FAIL %s_wl got=%0d exp=2", tag, ifa.words_loaded_o); end
        checks++; if (ifa.upg_dat_o !== 32'h88776655) begin failures++; $display("FAIL %s_dat_hold got=%h exp=88776655", tag, ifa.upg_dat_o); end
    endtask

    task automatic test_zero_len();
        clear_logs();
        send('{8'h00, 8'hFF}, 1'b0);
        checks++; if (ifa.upg_done_o !== 1'b1) begin failures++; $display("FAIL zlen_garbage_done got=%b exp=1", ifa.upg_done_o); end
        send('{8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
        @(negedge clk);
        checks++; if (log_adr.size() != 0) begin failures++; $display("FAIL zlen_nwrites got=%0d exp=0", log_adr.size()); end
        checks++; if (ifa.upg_done_o !== 1'b1) begin failures++; $display("FAIL zlen_done got=%b exp=1", ifa.upg_done_o); end
        checks++; if (ifa.load_err_o !== 1'b0) begin failures++; $display("FAIL zlen_err got=%b exp=0", ifa.load_err_o); end
        checks++; if (ifa.words_loaded_o !== 16'd0) begin failures++; $display("FAIL zlen_wl got=%0d exp=0", ifa.words_loaded_o); end
    endtask

    task automatic test_timeout();
        int waited;
        clear_logs();
        send('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22}, 1'b0);
        checks++; if (ifa.upg_done_o !== 1'b0) begin failures++; $display("FAIL tmo_busy done=%b exp=0", ifa.upg_done_o); end
        waited = 0;
        while (ifa.upg_done_o !== 1'b1 && waited < 4 * TMO) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (ifa.upg_done_o !== 1'b1) begin failures++; $display("FAIL tmo_expire done=%b after %0d cycles exp=1", ifa.upg_done_o, waited); end
        checks++; if (waited < TMO - 4 || waited > TMO + 2) begin failures++; $display("FAIL tmo_latency got=%0d exp~%0d", waited, TMO); end
        checks++; if (ifa.load_err_o !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", ifa.load_err_o); end
        checks++; if (log_adr.size() != 0) begin failures++; $display("FAIL tmo_nwrites got=%0d exp=0", log_adr.size()); end
        send('{8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
        @(negedge clk);
        checks++; if (ifa.load_err_o !== 1'b0) begin failures++; $display("FAIL tmo_clear_err got=%b exp=0", ifa.load_err_o); end
    endtask

    task automatic test_reset_mid();
        int n0;
        clear_logs();
        send('{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 1'b0);
        n0 = log_adr.size();
        checks++; if (n0 != 1) begin failures++; $display("FAIL rmid_pre_writes got=%0d exp=1", n0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ifa.upg_dat_o !== 32'd0) begin failures++; $display("FAIL rmid_dat got=%h exp=0", ifa.upg_dat_o); end
        checks++; if (ifa.upg_done_o !== 1'b1) begin failures++; $display("FAIL rmid_done got=%b exp=1", ifa.upg_done_o); end
        checks++; if (ifa.words_loaded_o !== 16'd0) begin failures++; $display("FAIL rmid_wl got=%0d exp=0", ifa.words_loaded_o); end
        checks++; if (ifa.upg_adr_o !== 14'd0 || ifa.upg_wen_o !== 1'b0 || ifa.load_err_o !== 1'b0) begin
            failures++; $display("FAIL rmid_misc adr=%h wen=%b err=%b exp 0/0/0", ifa.upg_adr_o, ifa.upg_wen_o, ifa.load_err_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send('{8'h08, 8'h00}, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (log_adr.size() != n0) begin failures++; $display("FAIL rmid_post_writes got=%0d exp=%0d", log_adr.size(), n0); end
        checks++; if (ifa.upg_done_o !== 1'b1) begin failures++; $display("FAIL rmid_post_done got=%b exp=1", ifa.upg_done_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] body[$];
        logic [7:0] frame[$];
        logic [31:0] w;
        // Four words on the full-depth instance, one byte every cycle.
        clear_logs();
        body = {8'h04, 8'h00};
        for (int i = 0; i < 16; i++) body.push_back(8'(8'h10 + i * 8'h0B));
        frame = {8'hA5};
        foreach (body[i]) frame.push_back(body[i]);
        frame.push_back(csum(body));
        send(frame, 1'b1);
        @(negedge clk);
        checks++; if (log_adr.size() != 4) begin failures++; $display("FAIL b2b_nwrites got=%0d exp=4", log_adr.size()); end
        else for (int k = 0; k < 4; k++) begin
            w = {body[2 + 4*k + 3], body[2 + 4*k + 2], body[2 + 4*k + 1], body[2 + 4*k]};
            checks++;
            if (log_adr[k] !== 14'(k) || log_dat[k] !== w) begin
                failures++; $display("FAIL b2b_w%0d adr=%h dat=%h exp %h/%h", k, log_adr[k], log_dat[k], k, w);
            end
        end
        checks++; if (ifa.load_err_o !== 1'b0 || ifa.words_loaded_o !== 16'd4) begin
            failures++; $display("FAIL b2b_status err=%b wl=%0d exp 0/4", ifa.load_err_o, ifa.words_loaded_o);
        end
        // Five words: the 4-word instance drops the fifth, the full one keeps it.
        clear_logs();
        body = {8'h05, 8'h00};
        for (int i = 0; i < 20; i++) body.push_back(8'(8'hC0 + i * 8'h07));
        frame = {8'hA5};
        foreach (body[i]) frame.push_back(body[i]);
        frame.push_back(csum(body));
        send(frame, 1'b1);
        @(negedge clk);
        checks++; if (logb_adr.size() != 4) begin failures++; $display("FAIL small_nwrites got=%0d exp=4", logb_adr.size()); end
        else for (int k = 0; k < 4; k++) begin
            w = {body[2 + 4*k + 3], body[2 + 4*k + 2], body[2 + 4*k + 1], body[2 + 4*k]};
            checks++;
            if (logb_adr[k] !== 2'(k) || logb_dat[k] !== w) begin
                failures++; $display("FAIL small_w%0d adr=%h dat=%h exp %h/%h", k, logb_adr[k], logb_dat[k], k, w);
            end
        end
        checks++; if (ifb.words_loaded_o !== 16'd4) begin failures++; $display("FAIL small_wl got=%0d exp=4", ifb.words_loaded_o); end
        checks++; if (ifb.load_err_o !== 1'b0 || ifb.upg_done_o !== 1'b1) begin
            failures++; $display("FAIL small_status err=%b done=%b exp 0/1", ifb.load_err_o, ifb.upg_done_o);
        end
        checks++; if (ifa.words_loaded_o !== 16'd5 || log_adr.size() != 5) begin
            failures++; $display("FAIL full5_wl wl=%0d writes=%0d exp 5/5", ifa.words_loaded_o, log_adr.size());
        end
        // Same five-word frame with a wrong checksum must still be caught on the small one.
        frame[frame.size()-1] = frame[frame.size()-1] ^ 8'h5A;
        send(frame, 1'b1);
        @(negedge clk);
        checks++; if (ifb.load_err_o !== 1'b1) begin failures++; $display("FAIL small_badchk err=%b exp=1", ifb.load_err_o); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic(8'h00, 1'b0, "good");
        test_basic(8'hFF, 1'b1, "badchk");
        test_zero_len();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
